// File: rtl/numeric_literal_parser.sv
// Streaming ASCII numeric-literal parser: hex (0x), binary (0b) and decimal
// literals with optional '-', sign/zero extension and overflow detection.
module numeric_literal_parser #(
    parameter int WIDTH         = 32,
    parameter bit ALLOW_DECIMAL = 1'b1
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             valid_data,
    input  logic             new_character,
    input  logic [7:0]       incoming_ascii,
    input  logic             sign_extend,
    output logic [WIDTH-1:0] value,
    output logic             done_flag,
    output logic             error_flag,
    output logic             overflow_flag
);

    localparam int AW = WIDTH + 5;
    localparam logic [AW-1:0] LIM_U = (AW'(1) << WIDTH) - AW'(1);
    localparam logic [AW-1:0] LIM_N = AW'(1) << (WIDTH - 1);

    localparam logic [7:0] C_MINUS = 8'h2D;
    localparam logic [7:0] C_ZERO  = 8'h30;

    typedef enum logic [2:0] {
        IDLE, SIGN, ZERO, HEX, BIN, DEC, RETURN, ERROR
    } state_t;

    state_t          st;
    logic [AW-1:0]   acc;
    logic [7:0]      cnt;
    logic            neg;
    logic            se_q;

    logic [7:0]      ch;
    logic            is_delim;
    logic            is_num;
    logic            is_hex;
    logic            is_x;
    logic            is_b;
    logic            dig_ok;
    logic            ovf;
    logic [3:0]      dval;
    logic [AW-1:0]   nxt;
    logic [AW-1:0]   lim;
    logic [9:0]      bits;
    logic [WIDTH-1:0] top;
    logic [WIDTH-1:0] low_mask;
    logic [WIDTH-1:0] formed;
    logic [WIDTH-1:0] result;

    assign ch = incoming_ascii;

    always_comb begin
        is_delim = (ch == 8'h20) || (ch == 8'h2C) ||
                   (ch == 8'h29) || (ch == 8'h0A);
        is_num   = (ch >= 8'h30) && (ch <= 8'h39);
        is_x     = (ch == 8'h78) || (ch == 8'h58);
        is_b     = (ch == 8'h62) || (ch == 8'h42);
        dval     = '0;
        is_hex   = 1'b0;
        if (is_num) begin
            dval   = ch[3:0];
            is_hex = 1'b1;
        end else if ((ch >= 8'h61 && ch <= 8'h66) ||
                     (ch >= 8'h41 && ch <= 8'h46)) begin
            // 'a'..'f' and 'A'..'F' share the low nibble 1..6
            dval   = ch[3:0] + 4'd9;
            is_hex = 1'b1;
        end

        dig_ok = is_num;
        nxt    = (acc << 3) + (acc << 1) + AW'(dval);
        case (st)
            HEX: begin
                dig_ok = is_hex;
                nxt    = (acc << 4) + AW'(dval);
            end
            BIN: begin
                dig_ok = is_num && (dval <= 4'd1);
                nxt    = (acc << 1) + AW'(dval);
            end
            default: ;
        endcase

        lim = (st == DEC && neg) ? LIM_N : LIM_U;
        ovf = nxt > lim;

        bits     = (st == HEX) ? {cnt, 2'b00} : {2'b00, cnt};
        top      = '0;
        low_mask = '1;
        formed   = acc[WIDTH-1:0];
        if (se_q && (st == HEX || st == BIN) &&
            bits != 10'd0 && bits < 10'(WIDTH)) begin
            top      = WIDTH'(1) << (bits - 10'd1);
            low_mask = (top << 1) - WIDTH'(1);
            if (|(formed & top))
                formed = formed | ~low_mask;
        end
        result = neg ? -formed : formed;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            st            <= IDLE;
            value         <= '0;
            done_flag     <= 1'b0;
            error_flag    <= 1'b0;
            overflow_flag <= 1'b0;
            acc           <= '0;
            cnt           <= '0;
            neg           <= 1'b0;
            se_q          <= 1'b0;
        end else begin
            done_flag <= 1'b0;
            if (!valid_data) begin
                st            <= IDLE;
                acc           <= '0;
                cnt           <= '0;
                neg           <= 1'b0;
                error_flag    <= 1'b0;
                overflow_flag <= 1'b0;
            end else if (!new_character) begin
                if (st == RETURN)
                    st <= IDLE;
            end else begin
                unique case (st)
                    IDLE, SIGN, RETURN: begin
                        if (is_delim) begin
                            if (st == SIGN) begin
                                st         <= ERROR;
                                error_flag <= 1'b1;
                            end else begin
                                st <= IDLE;
                            end
                        end else if (ch == C_MINUS) begin
                            if (st == SIGN) begin
                                st         <= ERROR;
                                error_flag <= 1'b1;
                            end else begin
                                neg <= 1'b1;
                                st  <= SIGN;
                            end
                        end else if (ch == C_ZERO) begin
                            st <= ZERO;
                        end else if (is_num && ALLOW_DECIMAL) begin
                            st  <= DEC;
                            acc <= AW'(dval);
                            cnt <= 8'd1;
                        end else begin
                            st         <= ERROR;
                            error_flag <= 1'b1;
                        end
                    end
                    ZERO: begin
                        if (is_x) begin
                            st <= HEX;
                        end else if (is_b) begin
                            st <= BIN;
                        end else if (is_delim) begin
                            st        <= RETURN;
                            done_flag <= 1'b1;
                            value     <= '0;
                            neg       <= 1'b0;
                        end else if (is_num && ALLOW_DECIMAL) begin
                            st  <= DEC;
                            acc <= AW'(dval);
                            cnt <= 8'd1;
                        end else begin
                            st         <= ERROR;
                            error_flag <= 1'b1;
                        end
                    end
                    HEX, BIN, DEC: begin
                        if (is_delim) begin
                            if (cnt == 8'd0) begin
                                st         <= ERROR;
                                error_flag <= 1'b1;
                            end else begin
                                st        <= RETURN;
                                done_flag <= 1'b1;
                                value     <= result;
                                acc       <= '0;
                                cnt       <= '0;
                                neg       <= 1'b0;
                            end
                        end else if (!dig_ok) begin
                            st         <= ERROR;
                            error_flag <= 1'b1;
                        end else if (ovf) begin
                            st            <= ERROR;
                            error_flag    <= 1'b1;
                            overflow_flag <= 1'b1;
                        end else begin
                            acc <= nxt;
                            if (cnt != 8'hFF)
                                cnt <= cnt + 8'd1;
                            if (cnt == 8'd0)
                                se_q <= sign_extend;
                        end
                    end
                    ERROR: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_numeric_literal_parser.sv
// Bench for numeric_literal_parser: two configurations driven in parallel
// and checked against a string-level literal model.
module tb_numeric_literal_parser;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid;
    logic        newc;
    logic [7:0]  ascii;
    logic        se;

    logic [31:0] val_a;
    logic        done_a, err_a, ovf_a;
    logic [15:0] val_b;
    logic        done_b, err_b, ovf_b;

    always #5 clk = ~clk;

    numeric_literal_parser #(.WIDTH(32), .ALLOW_DECIMAL(1'b1)) dut_a (
        .clk_in(clk), .rst_n_in(rst_n), .valid_data(valid),
        .new_character(newc), .incoming_ascii(ascii), .sign_extend(se),
        .value(val_a), .done_flag(done_a), .error_flag(err_a),
        .overflow_flag(ovf_a)
    );

    numeric_literal_parser #(.WIDTH(16), .ALLOW_DECIMAL(1'b0)) dut_b (
        .clk_in(clk), .rst_n_in(rst_n), .valid_data(valid),
        .new_character(newc), .incoming_ascii(ascii), .sign_extend(se),
        .value(val_b), .done_flag(done_b), .error_flag(err_b),
        .overflow_flag(ovf_b)
    );

    int ncmp = 0;
    int nerr = 0;
    int da, db;
    int lit_no = 0;
    longint unsigned last_a = 0;
    longint unsigned last_b = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_dl(byte c);
        return c == 8'h20 || c == 8'h2C || c == 8'h29 || c == 8'h0A;
    endfunction

    function automatic int dig(byte c);
        if (c >= "0" && c <= "9") return int'(c) - 48;
        if (c >= "a" && c <= "f") return int'(c) - 87;
        if (c >= "A" && c <= "F") return int'(c) - 55;
        return -1;
    endfunction

    // st: 0 literal completes, 1 format error, 2 magnitude overflow
    function automatic void model(input string s, input int w, input bit ad,
                                  input bit sx, output int st,
                                  output longint unsigned v);
        longint unsigned mask = (64'd1 << w) - 1;
        longint unsigned mag = 0;
        longint unsigned lim;
        int i = 0;
        int base = 0;
        int n = 0;
        int d;
        int bits;
        bit neg = 0;
        bit closed = 0;
        byte c2;
        st = 1;
        v = 0;
        if (s.len() > 0 && s[0] == "-") begin
            neg = 1;
            i = 1;
        end
        if (i + 1 >= s.len()) return;
        if (s[i] == "0") begin
            c2 = s[i+1];
            if (is_dl(c2)) begin
                st = 0;
                return;
            end
            if (c2 == "x" || c2 == "X") begin
                base = 16;
                i += 2;
            end else if (c2 == "b" || c2 == "B") begin
                base = 2;
                i += 2;
            end else if (ad && c2 >= "0" && c2 <= "9") begin
                base = 10;
                i += 1;
            end else begin
                return;
            end
        end else if (ad && s[i] >= "1" && s[i] <= "9") begin
            base = 10;
        end else begin
            return;
        end
        lim = (base == 10 && neg) ? (64'd1 << (w - 1)) : mask;
        for (int j = i; j < s.len(); j++) begin
            if (is_dl(s[j])) begin
                if (n == 0) return;
                closed = 1;
                break;
            end
            d = dig(s[j]);
            if (d < 0 || d >= base) return;
            mag = mag * longint'(base) + longint'(d);
            if (mag > lim) begin
                st = 2;
                return;
            end
            n++;
        end
        if (!closed) return;
        v = mag;
        bits = (base == 16) ? 4 * n : n;
        if (sx && base != 10 && bits < w && ((mag >> (bits - 1)) & 1) == 1)
            v = mag - (64'd1 << bits);
        if (neg) v = -v;
        v = v & mask;
        st = 0;
    endfunction

    function automatic string app(string s, byte c);
        string t = " ";
        t.putc(0, c);
        return {s, t};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        if (done_a) da++;
        if (done_b) db++;
    endtask

    task automatic send(byte c);
        @(negedge clk);
        newc  = 1'b1;
        ascii = c;
        step();
        newc  = 1'b0;
    endtask

    task automatic abort();
        @(negedge clk);
        valid = 1'b0;
        step();
        @(negedge clk);
        valid = 1'b1;
    endtask

    task automatic run_lit(input string s, input bit sev, input int gap);
        int sa, sb;
        longint unsigned va, vb;
        lit_no++;
        model(s, 32, 1'b1, sev, sa, va);
        model(s, 16, 1'b0, sev, sb, vb);
        if (sa == 0) last_a = va;
        if (sb == 0) last_b = vb;
        abort();
        chk($sformatf("abort_err_a#%0d", lit_no), err_a, 0);
        chk($sformatf("abort_err_b#%0d", lit_no), err_b, 0);
        se = sev;
        da = 0;
        db = 0;
        for (int j = 0; j < s.len(); j++) begin
            send(s[j]);
            if (j != s.len() - 1) repeat (gap) step();
        end
        chk($sformatf("done_a#%0d", lit_no), done_a, 64'(sa == 0));
        chk($sformatf("done_b#%0d", lit_no), done_b, 64'(sb == 0));
        chk($sformatf("val_a#%0d", lit_no), val_a, last_a);
        chk($sformatf("val_b#%0d", lit_no), val_b, last_b);
        chk($sformatf("err_a#%0d", lit_no), err_a, 64'(sa != 0));
        chk($sformatf("err_b#%0d", lit_no), err_b, 64'(sb != 0));
        chk($sformatf("ovf_a#%0d", lit_no), ovf_a, 64'(sa == 2));
        chk($sformatf("ovf_b#%0d", lit_no), ovf_b, 64'(sb == 2));
        step();
        chk($sformatf("pulses_a#%0d", lit_no), 64'(da), 64'(sa == 0));
        chk($sformatf("pulses_b#%0d", lit_no), 64'(db), 64'(sb == 0));
    endtask

    function automatic string gen();
        string hx = "0123456789abcdefABCDEF";
        string junk = "-0xbGz9";
        string dl = " ,)\n";
        string s = "";
        int f = $urandom_range(0, 3);
        int n;
        if ($urandom_range(0, 3) == 0) s = app(s, "-");
        case (f)
            0: begin
                s = {s, ($urandom_range(0, 1) == 0) ? "0x" : "0X"};
                n = $urandom_range(1, 10);
                repeat (n) s = app(s, hx[$urandom_range(0, 21)]);
            end
            1: begin
                s = {s, ($urandom_range(0, 1) == 0) ? "0b" : "0B"};
                n = $urandom_range(1, 36);
                repeat (n) s = app(s, hx[$urandom_range(0, 1)]);
            end
            2: begin
                n = $urandom_range(1, 10);
                repeat (n) s = app(s, hx[$urandom_range(0, 9)]);
            end
            default: begin
                n = $urandom_range(1, 4);
                repeat (n) s = app(s, junk[$urandom_range(0, 6)]);
            end
        endcase
        if ($urandom_range(0, 9) == 0)
            s.putc($urandom_range(0, s.len() - 1), junk[$urandom_range(0, 6)]);
        return app(s, dl[$urandom_range(0, 3)]);
    endfunction

    initial begin
        rst_n = 1'b0;
        valid = 1'b0;
        newc  = 1'b0;
        ascii = 8'h00;
        se    = 1'b0;
        step();
        step();
        chk("rst_val_a", val_a, 0);
        chk("rst_done_a", done_a, 0);
        chk("rst_err_a", err_a, 0);
        chk("rst_ovf_a", ovf_a, 0);
        chk("rst_val_b", val_b, 0);
        chk("rst_done_b", done_b, 0);
        chk("rst_err_b", err_b, 0);
        chk("rst_ovf_b", ovf_b, 0);
        @(negedge clk);
        rst_n = 1'b1;
        valid = 1'b1;

        run_lit("0xF,", 1'b1, 0);
        chk("c_0xF_a", val_a, 64'hFFFF_FFFF);
        chk("c_0xF_b", val_b, 64'hFFFF);
        run_lit("0x7F ", 1'b0, 0);
        chk("c_7F_zx", val_a, 64'h7F);
        run_lit("0x7F ", 1'b1, 0);
        chk("c_7F_sx", val_a, 64'h7F);
        run_lit("0b101 ", 1'b1, 0);
        chk("c_b101", val_a, 64'hFFFF_FFFD);
        run_lit("-2147483648 ", 1'b0, 0);
        chk("c_minint", val_a, 64'h8000_0000);
        run_lit("4294967295 ", 1'b0, 0);
        chk("c_maxu", val_a, 64'hFFFF_FFFF);
        run_lit("4294967296 ", 1'b0, 0);
        chk("c_ovf_dec", ovf_a, 1);
        chk("c_ovf_hold", val_a, 64'hFFFF_FFFF);
        run_lit("0x123456789 ", 1'b0, 0);
        chk("c_ovf_hex", ovf_a, 1);
        run_lit("0x1G ", 1'b0, 0);
        chk("c_bad_digit_ovf", ovf_a, 0);
        run_lit("0x ", 1'b0, 0);
        run_lit("-0x1 ", 1'b1, 0);
        run_lit("0x8000 ", 1'b1, 0);
        run_lit("-32768 ", 1'b0, 0);
        run_lit("0b12 ", 1'b0, 0);
        run_lit("12a ", 1'b0, 0);
        run_lit("-- ", 1'b0, 0);
        run_lit("- ", 1'b0, 0);
        run_lit("0123)", 1'b0, 0);

        send("0");
        send("x");
        send("1");
        send("2");
        run_lit("0x34 ", 1'b0, 0);
        chk("c_abort_resume", val_a, 64'h34);

        send("0");
        send("x");
        send("5");
        @(negedge clk);
        rst_n = 1'b0;
        step();
        chk("midrst_val_a", val_a, 0);
        chk("midrst_val_b", val_b, 0);
        chk("midrst_flags_a", {done_a, err_a, ovf_a}, 0);
        chk("midrst_flags_b", {done_b, err_b, ovf_b}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        last_a = 0;
        last_b = 0;

        run_lit("5 ", 1'b0, 0);
        run_lit("0x5A ", 1'b0, 0);
        run_lit("0 ", 1'b0, 0);
        chk("c_zero_b", val_b, 0);
        run_lit("5 ", 1'b0, 3);
        run_lit("0xF,", 1'b1, 3);
        run_lit("0b101 ", 1'b1, 3);
        run_lit("4294967296 ", 1'b0, 3);
        run_lit("0 ", 1'b0, 3);

        for (int k = 0; k < 160; k++)
            run_lit(gen(), 1'($urandom_range(0, 1)), $urandom_range(0, 2));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
